// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding for the sequential signed multiplier.
package mult_pkg;
  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/seq_signed_mult_addsub.sv
// addsub_n: combinational (WIDTH+1)-bit sign-extending adder/subtracter.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             X
);
  logic [WIDTH:0] bx;
  // Subtraction is ~B plus a carry-in of one; carry out of bit WIDTH drops.
  assign bx = {B[WIDTH-1], B} ^ {(WIDTH+1){Sub}};
  assign {X, Sum} = {A[WIDTH-1], A} + bx + {{WIDTH{1'b0}}, Sub};
endmodule

// File: rtl/seq_signed_mult.sv
// seq_signed_mult: sequential two's-complement add-shift multiplier with load/run handshake.
module seq_signed_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  state_t state;
  logic [WIDTH-1:0] a, b, s_reg, sum;
  logic x, sum_x, last;
  logic [CNT_W-1:0] cnt;
  // The final iteration carries negative weight, so it subtracts.
  assign last = cnt == CNT_W'(WIDTH-1);
  addsub_n #(.WIDTH(WIDTH)) u_addsub (.A(a), .B(s_reg), .Sub(last), .Sum(sum), .X(sum_x));
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      x <= 1'b0;
      s_reg <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a <= '0;
            x <= 1'b0;
            b <= Switches;
          end else if (Run) state <= CLR;
        end
        CLR: begin
          a <= '0;
          x <= 1'b0;
          s_reg <= Switches;
          cnt <= '0;
          state <= ADD;
        end
        ADD: begin
          if (b[0]) {x, a} <= {sum_x, sum};
          else x <= a[WIDTH-1];
          state <= SHIFT;
        end
        SHIFT: begin
          a <= {x, a[WIDTH-1:1]};
          b <= {a[0], b[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          state <= last ? HOLD : ADD;
        end
        HOLD: if (!Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign Aval = a;
  assign Bval = b;
  assign X = x;
  assign Busy = state == CLR || state == ADD || state == SHIFT;
  assign Done = state == HOLD;
endmodule
